// File: rtl/pipe_out_block_reader.sv
// Host-side reader for the 32-bit pattern output FIFO. Arms when a full
// block is buffered, converts host read strobes into FIFO reads and returns
// one word per strobe two cycles later. Counts blocks, flags protocol errors.
module pipe_out_block_reader #(
  parameter int BLOCK_WORDS = 128,
  parameter int COUNT_W     = 10
) (
  input  logic               okClk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] fifo_rd_count,
  input  logic               fifo_empty,
  input  logic [31:0]        fifo_dout,
  input  logic               fifo_valid,
  output logic               fifo_rd_en,
  output logic               ep_ready,
  input  logic               ep_read,
  output logic [31:0]        ep_datain,
  output logic               ep_dvalid,
  output logic               block_done,
  output logic [15:0]        blocks_sent,
  output logic               err_underrun,
  output logic               err_stray,
  input  logic               err_clr
);

  localparam int WC_W = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [2:0] {IDLE, ARMED, BURST, DRAIN, SETTLE} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] word_cnt, word_cnt_nxt;
  logic            settle_cnt;
  logic            open_blk, take, underrun, stray, last_take, done_nxt;
  // vld_pipe[1]: strobe taken last cycle (FIFO data now on fifo_dout)
  // vld_pipe[2]: word presented on ep_datain this cycle
  logic [2:1]      vld_pipe, last_pipe;
  logic            und_p1;

  // Strobe classification; the FIFO is only read when it actually has data
  always_comb begin
    open_blk   = (state == ARMED) || (state == BURST);
    take       = ep_read & open_blk;
    underrun   = take & fifo_empty;
    stray      = ep_read & ~open_blk;
    fifo_rd_en = take & ~fifo_empty;
    last_take  = take & (state == BURST) & (word_cnt == WC_W'(BLOCK_WORDS - 1));
    done_nxt   = (state == DRAIN) & last_pipe[2];
  end

  // ep_ready comes straight off the state register
  assign ep_ready  = (state == ARMED);
  assign ep_dvalid = vld_pipe[2];

  // Next-state and word counter
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    case (state)
      IDLE:
        if (fifo_rd_count >= COUNT_W'(BLOCK_WORDS)) begin
          state_nxt    = ARMED;
          word_cnt_nxt = '0;
        end
      ARMED:
        if (take) begin
          state_nxt    = BURST;
          word_cnt_nxt = WC_W'(1);
        end
      BURST:
        if (take) begin
          word_cnt_nxt = word_cnt + WC_W'(1);
          if (last_take) state_nxt = DRAIN;
        end
      DRAIN:
        if (last_pipe[2]) state_nxt = SETTLE;
      SETTLE:
        if (settle_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; SETTLE lasts two cycles so the FIFO count catches up
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      settle_cnt <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_cnt_nxt;
      settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
    end
  end

  // Return pipeline: underrun words come back as zero on the same schedule
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      und_p1    <= 1'b0;
      ep_datain <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], take};
      last_pipe <= {last_pipe[1], last_take};
      und_p1    <= underrun;
      ep_datain <= (vld_pipe[1] & ~und_p1 & fifo_valid) ? fifo_dout : 32'h0;
    end
  end

  // Block completion pulse, block counter and sticky errors (set beats clear)
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      block_done   <= 1'b0;
      blocks_sent  <= '0;
      err_underrun <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      block_done <= done_nxt;
      if (done_nxt) blocks_sent <= blocks_sent + 16'd1;
      if (underrun)     err_underrun <= 1'b1;
      else if (err_clr) err_underrun <= 1'b0;
      if (stray)        err_stray <= 1'b1;
      else if (err_clr) err_stray <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_out_block_reader.sv
// Directed bench for pipe_out_block_reader with a simple FIFO model.
module tb_pipe_out_block_reader;
  localparam int BW = 128;
  localparam int CW = 10;

  logic          okClk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] fifo_rd_count;
  logic          fifo_empty;
  logic [31:0]   fifo_dout = '0;
  logic          fifo_valid = 1'b0;
  logic          fifo_rd_en, ep_ready;
  logic          ep_read = 1'b0;
  logic [31:0]   ep_datain;
  logic          ep_dvalid, block_done;
  logic [15:0]   blocks_sent;
  logic          err_underrun, err_stray;
  logic          err_clr = 1'b0;

  pipe_out_block_reader #(.BLOCK_WORDS(BW), .COUNT_W(CW)) dut (
    .okClk(okClk), .reset(reset), .fifo_rd_count(fifo_rd_count),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_rd_en(fifo_rd_en), .ep_ready(ep_ready), .ep_read(ep_read),
    .ep_datain(ep_datain), .ep_dvalid(ep_dvalid), .block_done(block_done),
    .blocks_sent(blocks_sent), .err_underrun(err_underrun),
    .err_stray(err_stray), .err_clr(err_clr));

  always #5 okClk = ~okClk;

  // FIFO model
  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        inj_empty = 1'b0;
  logic        fifo_flush = 1'b0;

  assign fifo_rd_count = CW'(wr_ptr - rd_ptr);
  assign fifo_empty    = (wr_ptr == rd_ptr) || inj_empty;

  always @(posedge okClk) begin
    fifo_valid <= fifo_rd_en;
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor
  int          n_chk = 0, n_fail = 0;
  int          ncyc = 0, lat_bad = 0, bd_cnt = 0, bd_cyc = 0, last_strb = 0;
  int          rd_empty_bad = 0, stray_bad = 0;
  bit          in_blk = 0, stray_win = 0;
  int          sq[$];
  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];

  always @(negedge okClk) begin
    ncyc = ncyc + 1;
    if (ep_read && in_blk) begin
      sq.push_back(ncyc);
      last_strb = ncyc;
    end
    if (ep_dvalid) begin
      rx_q.push_back(ep_datain);
      if (sq.size() == 0) lat_bad = lat_bad + 1;
      else if (ncyc != sq.pop_front() + 2) lat_bad = lat_bad + 1;
    end
    if (block_done) begin
      bd_cnt = bd_cnt + 1;
      bd_cyc = ncyc;
    end
    if (fifo_rd_en && fifo_empty) rd_empty_bad = rd_empty_bad + 1;
    if (stray_win && (fifo_rd_en || ep_dvalid)) stray_bad = stray_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input bit add_exp);
    mem[wr_ptr % 1024] = v;
    wr_ptr = wr_ptr + 1;
    if (add_exp) exp_q.push_back(v);
  endtask

  task automatic wait_ready(input string nm);
    for (int k = 0; k < 100; k++) begin
      @(negedge okClk); #1;
      if (ep_ready) break;
    end
    chk({nm, "_ready"}, ep_ready, 1);
  endtask

  task automatic pulse_clr();
    @(posedge okClk); #1 err_clr = 1'b1;
    @(posedge okClk); #1 err_clr = 1'b0;
  endtask

  // Issue BW strobes (optionally alternating with a 10-cycle gap), injecting
  // FIFO-empty on strobes ulo..uhi-1, then check the returned block.
  task automatic run_blk(input string nm, input bit alt, input int ulo, input int uhi);
    int bd0, bad, k;
    rx_q = {};
    bd0 = bd_cnt;
    in_blk = 1;
    for (int i = 0; i < BW; i++) begin
      @(posedge okClk); #1;
      ep_read = 1'b1;
      inj_empty = (i >= ulo && i < uhi);
      if (i == 0) begin @(negedge okClk); chk({nm, "_rdy_hold"}, ep_ready, 1); end
      if (i == 1) begin @(negedge okClk); chk({nm, "_rdy_fall"}, ep_ready, 0); end
      if (alt) begin
        @(posedge okClk); #1;
        ep_read = 1'b0;
        inj_empty = 1'b0;
        if (i == 64) repeat (10) @(posedge okClk);
      end
    end
    @(posedge okClk); #1;
    ep_read = 1'b0;
    inj_empty = 1'b0;
    in_blk = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge okClk); #1;
      if (bd_cnt != bd0) break;
    end
    chk({nm, "_bd_once"}, bd_cnt - bd0, 1);
    chk({nm, "_bd_lat"}, bd_cyc - last_strb, 3);
    chk({nm, "_nwords"}, rx_q.size(), BW);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    chk({nm, "_data"}, bad, 0);
    chk({nm, "_lat"}, lat_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset values, FIFO preloaded with 127 words
    for (int i = 0; i < 127; i++) push(32'(i), 1);
    #12;
    chk("rst_ready", ep_ready, 0);
    chk("rst_rden", fifo_rd_en, 0);
    chk("rst_data", ep_datain, 0);
    chk("rst_dvalid", ep_dvalid, 0);
    chk("rst_bd", block_done, 0);
    chk("rst_blocks", blocks_sent, 0);
    chk("rst_und", err_underrun, 0);
    chk("rst_stray", err_stray, 0);
    @(posedge okClk); #1 reset = 1'b0;

    // 127 words never arms; the 128th arms on the next cycle
    seen = 0;
    repeat (50) begin
      @(negedge okClk);
      if (ep_ready) seen++;
    end
    chk("rdy_127", seen, 0);
    @(posedge okClk); #1 push(32'd127, 1);
    @(negedge okClk); chk("rdy_same", ep_ready, 0);
    @(negedge okClk); chk("rdy_next", ep_ready, 1);

    // Block 1: 128 back-to-back strobes
    run_blk("b1", 0, -1, -1);
    chk("b1_blocks", blocks_sent, 1);
    chk("b1_errs", {err_underrun, err_stray}, 0);

    // Stray read in IDLE, then clear, then set-and-clear together
    repeat (5) @(posedge okClk);
    stray_win = 1;
    @(posedge okClk); #1 ep_read = 1'b1;
    @(posedge okClk); #1 ep_read = 1'b0;
    repeat (3) @(posedge okClk);
    stray_win = 0;
    chk("idle_stray", err_stray, 1);
    chk("idle_stray_io", stray_bad, 0);
    pulse_clr();
    chk("stray_clr", err_stray, 0);
    @(posedge okClk); #1 begin ep_read = 1'b1; err_clr = 1'b1; end
    @(posedge okClk); #1 begin ep_read = 1'b0; err_clr = 1'b0; end
    chk("set_wins", err_stray, 1);
    pulse_clr();
    chk("stray_clr2", err_stray, 0);

    // Block 2: alternating strobes with a 10-cycle gap, then stray in SETTLE
    exp_q = {};
    for (int i = 0; i < BW; i++) push(32'h2000 + 32'(i), 1);
    wait_ready("b2");
    run_blk("b2", 1, -1, -1);
    chk("b2_blocks", blocks_sent, 2);
    chk("b2_errs", {err_underrun, err_stray}, 0);
    stray_win = 1;
    @(posedge okClk); #1 ep_read = 1'b1;
    @(posedge okClk); #1 ep_read = 1'b0;
    repeat (3) @(posedge okClk);
    stray_win = 0;
    chk("settle_stray", err_stray, 1);
    chk("settle_stray_io", stray_bad, 0);
    chk("settle_blocks", blocks_sent, 2);
    pulse_clr();

    // Block 3: 130 words, 10 empties injected on strobes 50..59
    exp_q = {};
    for (int i = 0; i < 130; i++) push(32'h3000 + 32'(i), 0);
    for (int i = 0; i < BW; i++)
      exp_q.push_back((i >= 50 && i < 60) ? 32'h0 :
                      (i < 50) ? 32'h3000 + 32'(i) : 32'h3000 + 32'(i - 10));
    wait_ready("b3");
    run_blk("b3", 0, 50, 60);
    chk("b3_und", err_underrun, 1);
    chk("b3_stray", err_stray, 0);
    chk("b3_blocks", blocks_sent, 3);
    chk("b3_left", wr_ptr - rd_ptr, 12);
    pulse_clr();
    chk("und_clr", err_underrun, 0);

    // Reset at word 60 of a block
    for (int i = 0; i < BW; i++) push(32'h4000 + 32'(i), 0);
    wait_ready("b4");
    in_blk = 1;
    repeat (60) begin @(posedge okClk); #1 ep_read = 1'b1; end
    @(posedge okClk); #1 ep_read = 1'b1;
    #1 chk("pre_rst_dv", ep_dvalid, 1);
    #1 begin reset = 1'b1; fifo_flush = 1'b1; end
    #1;
    chk("mid_rst_ready", ep_ready, 0);
    chk("mid_rst_rden", fifo_rd_en, 0);
    chk("mid_rst_data", ep_datain, 0);
    chk("mid_rst_dvalid", ep_dvalid, 0);
    chk("mid_rst_blocks", blocks_sent, 0);
    ep_read = 1'b0;
    in_blk = 0;
    @(posedge okClk); #1 fifo_flush = 1'b0;
    sq = {};
    exp_q = {};
    for (int i = 0; i < BW; i++) push(32'h5000 + 32'(i), 1);
    @(posedge okClk); #1 reset = 1'b0;
    wait_ready("b5");
    run_blk("b5", 0, -1, -1);
    chk("b5_blocks", blocks_sent, 1);
    chk("b5_errs", {err_underrun, err_stray}, 0);

    chk("rden_while_empty", rd_empty_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
